// File: rtl/pc_sequencer.sv
// Program-counter sequencer: INIT/FETCH/WAIT/EXEC/HALTED control that decodes the next PC and the counter load strobe.
// Optional interrupt entry/return (IRQ, Reti, IRQ_ack, EPC, mask) is built when PC_SEQ_IRQ_EN is defined.
module pc_sequencer #(
  parameter int unsigned     N            = 16,
  parameter logic [N-1:0]    RESET_VECTOR = '0,
  parameter logic [N-1:0]    IRQ_VECTOR   = N'(4)
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [N-1:0] PC_cur,
  input  logic         Instr_valid,
  input  logic         Stall,
  input  logic         Branch_taken,
  input  logic [N-1:0] Branch_offset,
  input  logic         Jump_req,
  input  logic [N-1:0] Jump_target,
  input  logic         Halt,
  input  logic         Resume,
`ifdef PC_SEQ_IRQ_EN
  input  logic         IRQ,
  input  logic         Reti,
  output logic         IRQ_ack,
  output logic [N-1:0] EPC,
`endif
  output logic [N-1:0] PC_in,
  output logic         PC_write_data,
  output logic         Fetch_en,
  output logic [2:0]   State
);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] pc_seq;
  logic [N-1:0] pc_chain;

`ifdef PC_SEQ_IRQ_EN
  logic         irq_take;
  logic         reti_take;
  logic         mask_q;
  logic         ack_q;
  logic [N-1:0] epc_q;
`endif

  // Address the Halt-free priority chain would load; wraps modulo 2^N.
  always_comb begin
    pc_seq   = PC_cur + N'(1);
    pc_chain = pc_seq;
    if (Jump_req) begin
      pc_chain = Jump_target;
    end else if (Branch_taken) begin
      pc_chain = pc_seq + Branch_offset;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus combinational PC load decode.
  always_comb begin
    state_nxt     = state;
    PC_in         = PC_cur;
    PC_write_data = 1'b0;
    Fetch_en      = 1'b0;
`ifdef PC_SEQ_IRQ_EN
    irq_take      = 1'b0;
    reti_take     = 1'b0;
`endif
    if (Reset) begin
      PC_in     = RESET_VECTOR;
      state_nxt = ST_INIT;
    end else begin
      case (state)
        ST_INIT: begin
          PC_in         = RESET_VECTOR;
          PC_write_data = 1'b1;
          state_nxt     = ST_FETCH;
        end
        ST_FETCH: begin
          Fetch_en  = 1'b1;
          state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (Instr_valid) state_nxt = ST_EXEC;
        end
        ST_EXEC: begin
          if (!Stall) begin
            if (Halt) begin
              state_nxt = ST_HALTED;
            end else begin
              state_nxt     = ST_FETCH;
              PC_write_data = 1'b1;
              PC_in         = pc_chain;
`ifdef PC_SEQ_IRQ_EN
              // Return beats a new interrupt; a masked interrupt falls through to the chain.
              if (Reti) begin
                reti_take = 1'b1;
                PC_in     = epc_q;
              end else if (IRQ && !mask_q) begin
                irq_take = 1'b1;
                PC_in    = IRQ_VECTOR;
              end
`endif
            end
          end
        end
        ST_HALTED: begin
          if (Resume) state_nxt = ST_FETCH;
        end
        default: state_nxt = ST_INIT;
      endcase
    end
  end

  assign State = state;

`ifdef PC_SEQ_IRQ_EN
  // EPC captures the address the interrupted instruction would have continued to.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mask_q <= 1'b0;
      ack_q  <= 1'b0;
      epc_q  <= '0;
    end else begin
      ack_q <= irq_take;
      if (irq_take) begin
        epc_q  <= pc_chain;
        mask_q <= 1'b1;
      end else if (reti_take) begin
        mask_q <= 1'b0;
      end
    end
  end

  assign IRQ_ack = ack_q & ~Reset;
  assign EPC     = Reset ? '0 : epc_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vectors, hand-computed literal checks, and a per-cycle spec-level model compare.
module tb_pc_sequencer;

  localparam logic [15:0] RV  = 16'h0000;
  localparam logic [15:0] IVA = 16'h0004;

  logic        Clock;
  logic        Reset;
  logic [15:0] PC_cur;
  logic        Instr_valid;
  logic        Stall;
  logic        Branch_taken;
  logic [15:0] Branch_offset;
  logic        Jump_req;
  logic [15:0] Jump_target;
  logic        Halt;
  logic        Resume;
  logic [15:0] PC_in;
  logic        PC_write_data;
  logic        Fetch_en;
  logic [2:0]  State;
`ifdef PC_SEQ_IRQ_EN
  logic        IRQ;
  logic        Reti;
  logic        IRQ_ack;
  logic [15:0] EPC;
`endif

  pc_sequencer #(.N(16), .RESET_VECTOR(RV), .IRQ_VECTOR(IVA)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .PC_cur        (PC_cur),
    .Instr_valid   (Instr_valid),
    .Stall         (Stall),
    .Branch_taken  (Branch_taken),
    .Branch_offset (Branch_offset),
    .Jump_req      (Jump_req),
    .Jump_target   (Jump_target),
    .Halt          (Halt),
    .Resume        (Resume),
`ifdef PC_SEQ_IRQ_EN
    .IRQ           (IRQ),
    .Reti          (Reti),
    .IRQ_ack       (IRQ_ack),
    .EPC           (EPC),
`endif
    .PC_in         (PC_in),
    .PC_write_data (PC_write_data),
    .Fetch_en      (Fetch_en),
    .State         (State)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase number (0 INIT,1 FETCH,2 WAIT,3 EXEC,4 HALTED) and interrupt bookkeeping.
  int          m_st;
  bit          m_mask;
  logic [15:0] m_epc;
  bit          m_ack;

  function automatic logic [15:0] chain_target();
    int a;
    if (Jump_req)          a = int'(Jump_target);
    else if (Branch_taken) a = int'(PC_cur) + 1 + int'(Branch_offset);
    else                   a = int'(PC_cur) + 1;
    return 16'(a % 65536);
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      m_st = 0; m_mask = 0; m_epc = 16'h0000; m_ack = 0;
    end else begin
      m_ack = 0;
      if (m_st == 0) m_st = 1;
      else if (m_st == 1) m_st = 2;
      else if (m_st == 2) begin
        if (Instr_valid) m_st = 3;
      end else if (m_st == 3) begin
        if (!Stall) begin
          if (Halt) m_st = 4;
          else begin
`ifdef PC_SEQ_IRQ_EN
            if (Reti) m_mask = 0;
            else if (IRQ && !m_mask) begin
              m_epc = chain_target(); m_mask = 1; m_ack = 1;
            end
`endif
            m_st = 1;
          end
        end
      end else if (m_st == 4) begin
        if (Resume) m_st = 1;
      end
    end
  end

  logic [15:0] e_pc;
  logic        e_wr;

  // Per-cycle comparison of every output against the model.
  always @(negedge Clock) begin
    if (chk_on) begin
      e_pc = PC_cur;
      e_wr = 1'b0;
      if (Reset) e_pc = RV;
      else if (m_st == 0) begin e_pc = RV; e_wr = 1'b1; end
      else if (m_st == 3 && !Stall && !Halt) begin
        e_wr = 1'b1;
        e_pc = chain_target();
`ifdef PC_SEQ_IRQ_EN
        if (Reti) e_pc = m_epc;
        else if (IRQ && !m_mask) e_pc = IVA;
`endif
      end
      chk("m_state", 32'(State), 32'(m_st));
      chk("m_pc_in", 32'(PC_in), 32'(e_pc));
      chk("m_pc_wr", 32'(PC_write_data), 32'(e_wr));
      chk("m_fetch", 32'(Fetch_en), 32'(!Reset && m_st == 1));
`ifdef PC_SEQ_IRQ_EN
      chk("m_ack", 32'(IRQ_ack), 32'(!Reset && m_ack));
      chk("m_epc", 32'(EPC), Reset ? 32'd0 : 32'(m_epc));
`endif
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // From the cycle FETCH is entered, advance to EXEC via one WAIT cycle.
  task automatic to_exec();
    tick();
    Instr_valid = 1'b1;
    tick();
    Instr_valid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; PC_cur = 16'h0000; Instr_valid = 1'b0; Stall = 1'b0;
    Branch_taken = 1'b0; Branch_offset = 16'h0000; Jump_req = 1'b0;
    Jump_target = 16'h0000; Halt = 1'b0; Resume = 1'b0;
`ifdef PC_SEQ_IRQ_EN
    IRQ = 1'b0; Reti = 1'b0;
`endif
    tick();
    chk_on = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge Clock);
    chk("init_pc", 32'(PC_in), 32'h0000);
    chk("init_wr", 32'(PC_write_data), 32'd1);
    tick();
    @(negedge Clock);
    chk("fetch_en", 32'(Fetch_en), 32'd1);
    tick();
    @(negedge Clock);
    chk("wait_state", 32'(State), 32'd2);
    tick();
    @(negedge Clock);
    chk("wait_hold", 32'(State), 32'd2);
    Instr_valid = 1'b1;
    tick();
    Instr_valid = 1'b0;
    PC_cur = 16'h0010;
    @(negedge Clock);
    chk("seq_pc", 32'(PC_in), 32'h0011);
    chk("seq_wr", 32'(PC_write_data), 32'd1);
    tick();
    @(negedge Clock);
    chk("back_fetch", 32'(State), 32'd1);
    chk("load_one_cycle", 32'(PC_write_data), 32'd0);

    to_exec();
    Branch_taken = 1'b1; Branch_offset = 16'hFFF0; Jump_req = 1'b1; Jump_target = 16'h0200;
    @(negedge Clock);
    chk("jump_priority", 32'(PC_in), 32'h0200);
    tick();
    Jump_req = 1'b0;
    to_exec();
    @(negedge Clock);
    chk("branch_neg", 32'(PC_in), 32'h0001);
    tick();
    Branch_taken = 1'b0;

    to_exec();
    PC_cur = 16'hFFFF;
    @(negedge Clock);
    chk("wrap_pc", 32'(PC_in), 32'h0000);
    tick();
    to_exec();
    Stall = 1'b1;
    Instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("stall_wr", 32'(PC_write_data), 32'd0);
      chk("stall_state", 32'(State), 32'd3);
      tick();
    end
    Stall = 1'b0;
    Instr_valid = 1'b0;
    @(negedge Clock);
    chk("post_stall_pc", 32'(PC_in), 32'h0000);
    tick();

    Resume = 1'b1;
    to_exec();
    Resume = 1'b0;
    Halt = 1'b1;
    @(negedge Clock);
    chk("halt_wr", 32'(PC_write_data), 32'd0);
    tick();
    Halt = 1'b0;
    @(negedge Clock);
    chk("halted", 32'(State), 32'd4);
    tick();
    @(negedge Clock);
    chk("halted_hold", 32'(State), 32'd4);
    Resume = 1'b1;
    tick();
    Resume = 1'b0;
    @(negedge Clock);
    chk("resume_fetch", 32'(State), 32'd1);
    tick();
    Reset = 1'b1;
    @(negedge Clock);
    chk("rst_wait_wr", 32'(PC_write_data), 32'd0);
    chk("rst_wait_pc", 32'(PC_in), 32'h0000);
    tick();
    Reset = 1'b0;
    @(negedge Clock);
    chk("rst_to_init", 32'(State), 32'd0);
    chk("rst_init_wr", 32'(PC_write_data), 32'd1);
    tick();

`ifdef PC_SEQ_IRQ_EN
    to_exec();
    PC_cur = 16'h0020;
    IRQ = 1'b1;
    @(negedge Clock);
    chk("irq_pc", 32'(PC_in), 32'h0004);
    tick();
    @(negedge Clock);
    chk("irq_ack", 32'(IRQ_ack), 32'd1);
    chk("irq_epc", 32'(EPC), 32'h0021);
    to_exec();
    @(negedge Clock);
    chk("irq_masked", 32'(PC_in), 32'h0021);
    chk("ack_one_cycle", 32'(IRQ_ack), 32'd0);
    tick();
    to_exec();
    PC_cur = 16'h0100;
    Reti = 1'b1;
    @(negedge Clock);
    chk("reti_pc", 32'(PC_in), 32'h0021);
    tick();
    Reti = 1'b0;
    to_exec();
    @(negedge Clock);
    chk("irq_unmasked", 32'(PC_in), 32'h0004);
    tick();
    IRQ = 1'b0;
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
